// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings and the main-control bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  typedef struct packed {
    logic reg_write;
    logic reg_read;
    logic mem_read;
    logic mem_write;
    logic to_reg;
    logic rt_rd;
  } ctrl_t;

endpackage

// File: rtl/mips_data_ram.sv
// Word-addressed data RAM: async read, sync write, sync clear on reset.
module mips_data_ram
  import mips_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [MEM_WORDS];
  logic [31:0] mem_d [MEM_WORDS];

  // Next memory image: reset clears every word and wins over a store.
  always_comb begin
    mem_d = mem_q;
    if (rst) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) begin
        mem_d[i] = '0;
      end
    end else if (we) begin
      mem_d[addr] = wdata;
    end
  end

  // Commit the memory image on the rising edge.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mips_exec_mem_unit.sv
// Single-cycle MIPS-32 execute/memory slice: control decode, ALU, data RAM, writeback mux.
module mips_exec_mem_unit
  import mips_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [15:0] immediate,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] pc,
  output logic        reg_write,
  output logic        reg_read,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        to_reg,
  output logic        rt_rd,
  output logic [31:0] alu_result,
  output logic [31:0] mem_read_data,
  output logic [31:0] write_data
);

  ctrl_t       ctrl;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic [4:0]  shamt;
  logic [31:0] ram_rdata;

  assign imm_sext = {{16{immediate[15]}}, immediate};
  assign imm_zext = {16'h0000, immediate};
  assign shamt    = immediate[10:6];

  // Main decode and ALU; unknown opcodes/functs fall back to all-zero.
  always_comb begin
    ctrl       = '0;
    alu_result = '0;
    branch     = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_read  = 1'b1;
        ctrl.rt_rd     = 1'b1;
        case (funct)
          F_ADD, F_ADDU: alu_result = rs_data + rt_data;
          F_SUB, F_SUBU: alu_result = rs_data - rt_data;
          F_AND:         alu_result = rs_data & rt_data;
          F_OR:          alu_result = rs_data | rt_data;
          F_XOR:         alu_result = rs_data ^ rt_data;
          F_NOR:         alu_result = ~(rs_data | rt_data);
          F_SLT:         alu_result = {31'b0, $signed(rs_data) < $signed(rt_data)};
          F_SLTU:        alu_result = {31'b0, rs_data < rt_data};
          F_SLL:         alu_result = rt_data << shamt;
          F_SRL:         alu_result = rt_data >> shamt;
          F_SRA:         alu_result = 32'($signed(rt_data) >>> shamt);
          F_JR: begin
            ctrl.reg_write = 1'b0;
            alu_result     = rs_data;
          end
          default:       ctrl = '0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_read  = 1'b1;
        case (opcode)
          OP_SLTI:  alu_result = {31'b0, $signed(rs_data) < $signed(imm_sext)};
          OP_SLTIU: alu_result = {31'b0, rs_data < imm_sext};
          OP_ANDI:  alu_result = rs_data & imm_zext;
          OP_ORI:   alu_result = rs_data | imm_zext;
          OP_XORI:  alu_result = rs_data ^ imm_zext;
          OP_LUI:   alu_result = {immediate, 16'h0000};
          default:  alu_result = rs_data + imm_sext;
        endcase
      end
      OP_LW: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_read  = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.to_reg    = 1'b1;
        alu_result     = rs_data + imm_sext;
      end
      OP_SW: begin
        ctrl.reg_read  = 1'b1;
        ctrl.mem_write = 1'b1;
        alu_result     = rs_data + imm_sext;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.reg_read = 1'b1;
        branch        = (opcode == OP_BEQ) ? (rs_data == rt_data) : (rs_data != rt_data);
        // Branch offset only; PC logic adds it to PC+4.
        alu_result    = branch ? {imm_sext[29:0], 2'b00} : 32'h0;
      end
      OP_J: ctrl = '0;
      OP_JAL: begin
        ctrl.reg_write = 1'b1;
        alu_result     = pc + 32'd4;
      end
      default: ctrl = '0;
    endcase
  end

  // Control bundle fan-out and writeback select.
  always_comb begin
    reg_write     = ctrl.reg_write;
    reg_read      = ctrl.reg_read;
    mem_read      = ctrl.mem_read;
    mem_write     = ctrl.mem_write;
    to_reg        = ctrl.to_reg;
    rt_rd         = ctrl.rt_rd;
    mem_read_data = ctrl.mem_read ? ram_rdata : 32'h0;
    write_data    = ctrl.to_reg ? mem_read_data : alu_result;
  end

  // Byte address low bits and bits above the RAM depth are dropped (wrap).
  mips_data_ram #(
    .MEM_WORDS(MEM_WORDS),
    .ADDR_W   (ADDR_W)
  ) u_data_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (ctrl.mem_write),
    .addr (alu_result[ADDR_W+1:2]),
    .wdata(rt_data),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_mips_exec_mem_unit.sv
// Self-checking bench: decode/ALU table plus memory sequences, checked via a scoreboard queue.
module tb_mips_exec_mem_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] immediate;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] pc;
  logic        reg_write, reg_read, mem_read, mem_write, branch, to_reg, rt_rd;
  logic [31:0] alu_result, mem_read_data, write_data;

  always #5 clk = ~clk;

  mips_exec_mem_unit #(
    .MEM_WORDS(256),
    .ADDR_W   (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .funct        (funct),
    .immediate    (immediate),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .pc           (pc),
    .reg_write    (reg_write),
    .reg_read     (reg_read),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .branch       (branch),
    .to_reg       (to_reg),
    .rt_rd        (rt_rd),
    .alu_result   (alu_result),
    .mem_read_data(mem_read_data),
    .write_data   (write_data)
  );

  // ctrl bit order: {reg_write, reg_read, mem_read, mem_write, branch, to_reg, rt_rd}
  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] pcv;
    logic [6:0]  ctrl;
    logic [31:0] alu;
    logic [31:0] mrd;
    logic [31:0] wd;
  } vec_t;

  typedef struct {
    string       name;
    logic [6:0]  ctrl;
    logic [31:0] alu;
    logic [31:0] mrd;
    logic [31:0] wd;
  } exp_t;

  localparam logic [6:0] C_R    = 7'b1100001;
  localparam logic [6:0] C_I    = 7'b1100000;
  localparam logic [6:0] C_LW   = 7'b1110010;
  localparam logic [6:0] C_SW   = 7'b0101000;
  localparam logic [6:0] C_BR_T = 7'b0100100;
  localparam logic [6:0] C_BR_N = 7'b0100000;
  localparam logic [6:0] C_JAL  = 7'b1000000;
  localparam logic [6:0] C_NONE = 7'b0000000;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t mk(string name, logic [5:0] op, logic [5:0] fn, logic [15:0] imm,
                              logic [31:0] rs, logic [31:0] rt, logic [31:0] pcv,
                              logic [6:0] ctrl, logic [31:0] alu, logic [31:0] wd);
    vec_t v;
    v.name = name; v.op = op; v.fn = fn; v.imm = imm; v.rs = rs; v.rt = rt; v.pcv = pcv;
    v.ctrl = ctrl; v.alu = alu; v.mrd = 32'h0; v.wd = wd;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Drive one instruction just after a rising edge and record its expected outputs.
  task automatic drive(string name, logic [5:0] op, logic [5:0] fn, logic [15:0] imm,
                       logic [31:0] rs, logic [31:0] rt, logic [31:0] pcv, logic r,
                       logic [6:0] ctrl, logic [31:0] alu, logic [31:0] mrd, logic [31:0] wd);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; opcode = op; funct = fn; immediate = imm;
    rs_data = rs; rt_data = rt; pc = pcv;
    e.name = name; e.ctrl = ctrl; e.alu = alu; e.mrd = mrd; e.wd = wd;
    sb.push_back(e);
  endtask

  // Compare the oldest outstanding expectation on the falling edge.
  task automatic observe();
    exp_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard: queue empty, expected 1 entry got 0");
      return;
    end
    e = sb.pop_front();
    chk({e.name, ".ctrl"},
        {25'h0, reg_write, reg_read, mem_read, mem_write, branch, to_reg, rt_rd},
        {25'h0, e.ctrl});
    chk({e.name, ".alu"}, alu_result, e.alu);
    chk({e.name, ".mrd"}, mem_read_data, e.mrd);
    chk({e.name, ".wd"}, write_data, e.wd);
  endtask

  task automatic step(string name, logic [5:0] op, logic [5:0] fn, logic [15:0] imm,
                      logic [31:0] rs, logic [31:0] rt, logic r, logic [6:0] ctrl,
                      logic [31:0] alu, logic [31:0] mrd, logic [31:0] wd);
    drive(name, op, fn, imm, rs, rt, 32'h0, r, ctrl, alu, mrd, wd);
    observe();
  endtask

  initial begin
    rst = 1'b1; opcode = 6'h0; funct = 6'h3F; immediate = '0;
    rs_data = '0; rt_data = '0; pc = '0;

    vecs.push_back(mk("add_ovf", 6'h00, 6'b100000, 16'h0, 32'h7FFFFFFF, 32'h1, 0, C_R,
                      32'h80000000, 32'h80000000));
    vecs.push_back(mk("addu", 6'h00, 6'b100001, 16'h0, 32'hFFFFFFFF, 32'h2, 0, C_R,
                      32'h1, 32'h1));
    vecs.push_back(mk("sub", 6'h00, 6'b100010, 16'h0, 32'h5, 32'h7, 0, C_R,
                      32'hFFFFFFFE, 32'hFFFFFFFE));
    vecs.push_back(mk("and", 6'h00, 6'b100100, 16'h0, 32'hF0F0, 32'hFF00, 0, C_R,
                      32'hF000, 32'hF000));
    vecs.push_back(mk("or", 6'h00, 6'b100101, 16'h0, 32'hF0F0, 32'hFF00, 0, C_R,
                      32'hFFF0, 32'hFFF0));
    vecs.push_back(mk("xor", 6'h00, 6'b100110, 16'h0, 32'hF0F0, 32'hFF00, 0, C_R,
                      32'h0FF0, 32'h0FF0));
    vecs.push_back(mk("nor", 6'h00, 6'b100111, 16'h0, 32'h0, 32'h0, 0, C_R,
                      32'hFFFFFFFF, 32'hFFFFFFFF));
    vecs.push_back(mk("slt", 6'h00, 6'b101010, 16'h0, 32'hFFFFFFFF, 32'h1, 0, C_R,
                      32'h1, 32'h1));
    vecs.push_back(mk("sltu", 6'h00, 6'b101011, 16'h0, 32'hFFFFFFFF, 32'h1, 0, C_R,
                      32'h0, 32'h0));
    vecs.push_back(mk("sll31", 6'h00, 6'b000000, 16'h07C0, 32'h0, 32'h1, 0, C_R,
                      32'h80000000, 32'h80000000));
    vecs.push_back(mk("srl4", 6'h00, 6'b000010, 16'h0100, 32'h0, 32'h80000000, 0, C_R,
                      32'h08000000, 32'h08000000));
    vecs.push_back(mk("sra4", 6'h00, 6'b000011, 16'h0100, 32'h0, 32'h80000000, 0, C_R,
                      32'hF8000000, 32'hF8000000));
    vecs.push_back(mk("addi_neg", 6'b001000, 6'h0, 16'hFFFF, 32'h10, 32'h0, 0, C_I,
                      32'hF, 32'hF));
    vecs.push_back(mk("slti", 6'b001010, 6'h0, 16'h0001, 32'hFFFFFFFE, 32'h0, 0, C_I,
                      32'h1, 32'h1));
    vecs.push_back(mk("sltiu", 6'b001011, 6'h0, 16'hFFFF, 32'h1, 32'h0, 0, C_I,
                      32'h1, 32'h1));
    vecs.push_back(mk("andi", 6'b001100, 6'h0, 16'h8001, 32'hFFFFFFFF, 32'h0, 0, C_I,
                      32'h00008001, 32'h00008001));
    vecs.push_back(mk("ori", 6'b001101, 6'h0, 16'h000F, 32'hF0000000, 32'h0, 0, C_I,
                      32'hF000000F, 32'hF000000F));
    vecs.push_back(mk("xori", 6'b001110, 6'h0, 16'h00FF, 32'h0000FFFF, 32'h0, 0, C_I,
                      32'h0000FF00, 32'h0000FF00));
    vecs.push_back(mk("lui", 6'b001111, 6'h0, 16'h1234, 32'hABCD, 32'h0, 0, C_I,
                      32'h12340000, 32'h12340000));
    vecs.push_back(mk("beq_taken", 6'b000100, 6'h0, 16'hFFFE, 32'h5, 32'h5, 0, C_BR_T,
                      32'hFFFFFFF8, 32'hFFFFFFF8));
    vecs.push_back(mk("bne_not", 6'b000101, 6'h0, 16'hFFFE, 32'h5, 32'h5, 0, C_BR_N,
                      32'h0, 32'h0));
    vecs.push_back(mk("bne_taken", 6'b000101, 6'h0, 16'h0003, 32'h5, 32'h6, 0, C_BR_T,
                      32'hC, 32'hC));
    vecs.push_back(mk("jal", 6'b000011, 6'h0, 16'h0, 32'h0, 32'h0, 32'h40, C_JAL,
                      32'h44, 32'h44));
    vecs.push_back(mk("bad_op", 6'h3F, 6'h0, 16'h1234, 32'h1, 32'h2, 0, C_NONE,
                      32'h0, 32'h0));
    vecs.push_back(mk("bad_funct", 6'h00, 6'h3F, 16'h0, 32'h1, 32'h2, 0, C_NONE,
                      32'h0, 32'h0));

    // Reset for one cycle, then first load sees a cleared word.
    @(posedge clk);
    #1 rst = 1'b1;
    step("lw_after_rst", 6'b100011, 6'h0, 16'h0010, 32'h0, 32'h0, 1'b0, C_LW,
         32'h10, 32'h0, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].name, vecs[i].op, vecs[i].fn, vecs[i].imm, vecs[i].rs, vecs[i].rt,
            vecs[i].pcv, 1'b0, vecs[i].ctrl, vecs[i].alu, vecs[i].mrd, vecs[i].wd);
      observe();
    end

    // jr: only alu_result and reg_write are pinned down.
    @(posedge clk);
    #1 opcode = 6'h00; funct = 6'b001000; rs_data = 32'h1234; rt_data = 32'h0;
    @(negedge clk);
    chk("jr.alu", alu_result, 32'h1234);
    chk("jr.reg_write", {31'h0, reg_write}, 32'h0);

    // Store then load the same (negative-offset) address.
    step("sw_fc", 6'b101011, 6'h0, 16'hFFFC, 32'h100, 32'hDEADBEEF, 1'b0, C_SW,
         32'hFC, 32'h0, 32'hFC);
    step("lw_fc", 6'b100011, 6'h0, 16'hFFFC, 32'h100, 32'h0, 1'b0, C_LW,
         32'hFC, 32'hDEADBEEF, 32'hDEADBEEF);

    // Store during reset is suppressed; reset also clears the earlier word.
    step("sw_in_rst", 6'b101011, 6'h0, 16'h0008, 32'h0, 32'hAAAA5555, 1'b1, C_SW,
         32'h8, 32'h0, 32'h8);
    step("lw_8_rst", 6'b100011, 6'h0, 16'h0008, 32'h0, 32'h0, 1'b0, C_LW,
         32'h8, 32'h0, 32'h0);
    step("lw_fc_rst", 6'b100011, 6'h0, 16'h00FC, 32'h0, 32'h0, 1'b0, C_LW,
         32'hFC, 32'h0, 32'h0);

    // Address 0x400 wraps to word 0; low address bits are ignored on read.
    step("sw_400", 6'b101011, 6'h0, 16'h0400, 32'h0, 32'h13579BDF, 1'b0, C_SW,
         32'h400, 32'h0, 32'h400);
    step("lw_0", 6'b100011, 6'h0, 16'h0000, 32'h0, 32'h0, 1'b0, C_LW,
         32'h0, 32'h13579BDF, 32'h13579BDF);
    step("lw_3", 6'b100011, 6'h0, 16'h0003, 32'h0, 32'h0, 1'b0, C_LW,
         32'h3, 32'h13579BDF, 32'h13579BDF);

    // An undefined opcode must not write memory.
    step("bad_op_nowr", 6'h3F, 6'h0, 16'h0000, 32'h0, 32'hFFFFFFFF, 1'b0, C_NONE,
         32'h0, 32'h0, 32'h0);
    step("lw_0_again", 6'b100011, 6'h0, 16'h0000, 32'h0, 32'h0, 1'b0, C_LW,
         32'h0, 32'h13579BDF, 32'h13579BDF);

    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
